icache_ctrl: RTL

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl_pkg.sv | 22 ++
 rtl/icache_array.sv | 51 +++++
 rtl/icache_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared types and widths for the instruction cache controller.
package icache_ctrl_pkg;

   localparam int WORD_W   = 32;
   localparam int BLOCK_W  = 128;
   localparam int OFFSET_W = 2;
   localparam int INDEX_W  = 3;
   localparam int TAG_W    = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FILL  = 2'd2
   } state_e;

   // Picks one 32-bit word out of a 16-byte block; word n sits at bits [32n+31:32n].
   function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                  input logic [OFFSET_W-1:0] off);
      return blk[{off, 5'd0} +: WORD_W];
   endfunction

endpackage

// File: rtl/icache_array.sv
// Line storage: valid bits (reset), tag and data arrays (no reset).
// One synchronous write port, one combinational read port.
module icache_array
   import icache_ctrl_pkg::*;
#(
   parameter int NLINES = 8,
   parameter int IDX_W  = 3,
   parameter int TG_W   = 3
) (
   input  logic               clk_sys,
   input  logic               rst_b,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [TG_W-1:0]    wr_tag,
   input  logic [BLOCK_W-1:0] wr_data,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic               rd_valid,
   output logic [TG_W-1:0]    rd_tag,
   output logic [BLOCK_W-1:0] rd_data
);

   logic [NLINES-1:0]  valid_d;
   logic [NLINES-1:0]  valid_q;
   logic [TG_W-1:0]    tag_q  [NLINES];
   logic [BLOCK_W-1:0] data_q [NLINES];

   // A completed fill marks its line valid; nothing ever invalidates except reset.
   always_comb begin
      valid_d = valid_q;
      if (wr_en) valid_d[wr_idx] = 1'b1;
   end

   // Valid bits are the only storage cleared by reset.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // Tag and data are meaningless until valid is set, so they carry no reset.
   always_ff @(posedge clk_sys) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | serve hits combinationally; a miss raises BUSYWAIT and
//           | captures index/tag for the refill
//   S_FETCH | MEM_READ held until MEM_BUSYWAIT falls; that edge writes
//           | the block into the captured line
//   S_FILL  | one settling cycle, then back to IDLE where the refetch hits
module icache_ctrl
   import icache_ctrl_pkg::*;
#(
   parameter int NLINES = 8,
   parameter int ADDR_W = 10
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [31:0]        PC,
   output logic [WORD_W-1:0]  INSTRUCTION,
   output logic               BUSYWAIT,
   output logic               MEM_READ,
   output logic [ADDR_W-5:0]  MEM_ADDRESS,
   input  logic [BLOCK_W-1:0] MEM_READDATA,
   input  logic               MEM_BUSYWAIT
);

   localparam int IDX_W = $clog2(NLINES);
   localparam int TG_W  = ADDR_W - 4 - IDX_W;

   state_e             state_d, state_q;
   logic [IDX_W-1:0]   cap_idx_d, cap_idx_q;
   logic [TG_W-1:0]    cap_tag_d, cap_tag_q;

   logic [OFFSET_W-1:0] pc_off;
   logic [IDX_W-1:0]    pc_idx;
   logic [TG_W-1:0]     pc_tag;
   logic                pc_unused;

   logic                rd_valid;
   logic [TG_W-1:0]     rd_tag;
   logic [BLOCK_W-1:0]  rd_data;
   logic                hit;
   logic                wr_en;

   assign pc_off    = PC[3:2];
   assign pc_idx    = PC[4 +: IDX_W];
   assign pc_tag    = PC[4+IDX_W +: TG_W];
   assign pc_unused = ^{PC[31:ADDR_W], PC[1:0]};

   assign hit = rd_valid && (rd_tag == pc_tag);

   // The refill lands on the same edge that leaves FETCH; the data is valid in
   // the cycle MEM_BUSYWAIT is low.
   assign wr_en = (state_q == S_FETCH) && !MEM_BUSYWAIT;

   // Address comes from the captured line so a PC wobble mid-miss cannot
   // redirect the refill.
   assign MEM_ADDRESS = {cap_tag_q, cap_idx_q};

   icache_array #(
      .NLINES (NLINES),
      .IDX_W  (IDX_W),
      .TG_W   (TG_W)
   ) u_array (
      .clk_sys  (CLK),
      .rst_b    (RESET),
      .wr_en    (wr_en),
      .wr_idx   (cap_idx_q),
      .wr_tag   (cap_tag_q),
      .wr_data  (MEM_READDATA),
      .rd_idx   (pc_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data)
   );

   // Next-state and output decode; outputs are forced quiet while reset is held
   // because an all-invalid cache would otherwise look like a miss.
   always_comb begin
      state_d     = state_q;
      cap_idx_d   = cap_idx_q;
      cap_tag_d   = cap_tag_q;
      BUSYWAIT    = 1'b0;
      MEM_READ    = 1'b0;
      INSTRUCTION = '0;
      unique case (state_q)
         S_IDLE: begin
            if (hit) begin
               INSTRUCTION = word_sel(rd_data, pc_off);
            end else begin
               BUSYWAIT  = 1'b1;
               state_d   = S_FETCH;
               cap_idx_d = pc_idx;
               cap_tag_d = pc_tag;
            end
         end
         S_FETCH: begin
            BUSYWAIT = 1'b1;
            MEM_READ = 1'b1;
            if (!MEM_BUSYWAIT) state_d = S_FILL;
         end
         S_FILL: begin
            BUSYWAIT = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (!RESET) begin
         BUSYWAIT    = 1'b0;
         MEM_READ    = 1'b0;
         INSTRUCTION = '0;
      end
   end

   // State and captured miss address.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= S_IDLE;
         cap_idx_q <= '0;
         cap_tag_q <= '0;
      end else begin
         state_q   <= state_d;
         cap_idx_q <= cap_idx_d;
         cap_tag_q <= cap_tag_d;
      end
   end

endmodule
